// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
// Issues one multiply/divide at a time to the multdiv unit. The controller
// latches the operands, emits a single start pulse and waits for the result.
// The result is held in an output register until the consumer acknowledges
// it. A watchdog forces an exception if the unit never answers.
module multdiv_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    output logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_operandB,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_result,
    input  logic             data_exception,
    input  logic             data_resultRDY,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_exception,
    output logic             result_timeout,
    input  logic             result_ack
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Final WAIT count before the watchdog fires
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [CNT_W-1:0] waitCnt;
    logic [WIDTH-1:0] opALatch;
    logic [WIDTH-1:0] opBLatch;
    logic             isDivLatch;
    logic [WIDTH-1:0] resultReg;
    logic             resultExcReg;
    logic             resultToReg;
    logic             watchdogHit;

    assign watchdogHit = (waitCnt == TIMEOUT_LAST);

    // Next-state selection; a result arriving on the watchdog's final cycle takes priority
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (op_valid) nextState = LAUNCH;
            LAUNCH:  nextState = WAIT;
            WAIT:    if (data_resultRDY || watchdogHit) nextState = DONE;
            DONE:    if (result_ack) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register; reset drops any operation in flight without emitting a pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operand latches, watchdog counter and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt      <= '0;
            opALatch     <= '0;
            opBLatch     <= '0;
            isDivLatch   <= 1'b0;
            resultReg    <= '0;
            resultExcReg <= 1'b0;
            resultToReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        opALatch   <= op_a;
                        opBLatch   <= op_b;
                        isDivLatch <= op_is_div;
                    end
                end
                LAUNCH: begin
                    waitCnt <= '0;
                end
                WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (data_resultRDY) begin
                        resultReg    <= data_result;
                        resultExcReg <= data_exception;
                        resultToReg  <= 1'b0;
                    end else if (watchdogHit) begin
                        resultReg    <= '0;
                        resultExcReg <= 1'b1;
                        resultToReg  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        op_ready         = (state == IDLE);
        busy             = (state != IDLE);
        result_valid     = (state == DONE);
        ctrl_MULT        = (state == LAUNCH) && !isDivLatch;
        ctrl_DIV         = (state == LAUNCH) && isDivLatch;
        data_operandA    = opALatch;
        data_operandB    = opBLatch;
        result           = resultReg;
        result_exception = resultExcReg;
        result_timeout   = resultToReg;
    end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Initiator side of the multdiv handshake. It accepts one multiply or divide request from the pipeline and latches the operands. It then pulses ctrl_MULT or ctrl_DIV to the multdiv unit, holds the operands stable, and waits for data_resultRDY. The result and exception are captured into an output register, held until acknowledged, with a watchdog timeout if the unit never responds.

Parameters:
WIDTH, 32, operand/result width
TIMEOUT, 40, max WAIT cycles before forced exception (multdiv nominal latency ≤ 34)
CNT_W, 6, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
op_valid  input  1  pipeline request present
op_is_div  input  1  1 = divide, 0 = multiply
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
op_ready  output  1  controller can accept a request
data_operandA  output  WIDTH  to multdiv, latched op_a
data_operandB  output  WIDTH  to multdiv, latched op_b
ctrl_MULT  output  1  one-cycle start pulse, multiply
ctrl_DIV  output  1  one-cycle start pulse, divide
data_result  input  WIDTH  from multdiv
data_exception  input  1  from multdiv
data_resultRDY  input  1  from multdiv, result valid this cycle
busy  output  1  operation in flight (pipeline stall)
result_valid  output  1  result register holds an unconsumed result
result  output  WIDTH  captured result
result_exception  output  1  captured exception (multdiv or timeout)
result_timeout  output  1  exception was caused by the watchdog
result_ack  input  1  consumer takes result

Behaviour:
- FSM states: IDLE, LAUNCH, WAIT, DONE. Reset (reset=0, asynchronous) forces IDLE. It also clears the counter, operand latches, result, result_exception, result_timeout and the op-type latch.
- Output values in reset: ctrl_MULT=ctrl_DIV=0, busy=0, result_valid=0, op_ready=1.
- IDLE: op_ready=1. On op_valid=1 at a clock edge: latch op_a, op_b and op_is_div, then go to LAUNCH. Without op_valid, stay in IDLE.
- LAUNCH, exactly 1 cycle: ctrl_DIV=1 if the latched op is divide, else ctrl_MULT=1. The two are never both high. Counter cleared to 0. data_resultRDY is ignored in this cycle. Next state is WAIT.
- WAIT: the counter increments each cycle.
  - data_resultRDY=1 → capture data_result into result and data_exception into result_exception; result_timeout=0; go to DONE.
  - Counter == TIMEOUT-1 with data_resultRDY=0 → result=0, result_exception=1, result_timeout=1; go to DONE.
  - data_resultRDY and the timeout in the same cycle → RDY wins (normal capture).
- DONE: result_valid=1, and result/result_exception/result_timeout are held stable. On result_ack=1 → IDLE; result_valid drops the next cycle. result_ack outside DONE is ignored.
- Latency: request edge → start pulse 1 cycle later. RDY edge → result_valid high the next cycle.
- busy=1 in LAUNCH, WAIT and DONE. op_ready=1 only in IDLE. op_valid while busy is ignored; no queuing, the requester must hold op_valid.
- data_operandA/B are driven from the latches in every state. They change only on acceptance in IDLE.
- The result registers retain their last value after returning to IDLE until the next capture.
- Reset asserted mid-operation: immediate return to IDLE and no pulse is emitted. A later data_resultRDY from the multdiv unit is ignored because the FSM is in IDLE.
- Back-to-back: result_ack and op_valid in consecutive cycles. The new request is accepted the cycle after DONE→IDLE, so minimum 1 IDLE cycle between ops.

Test Plan:
- Mult: op_a=7, op_b=6, op_is_div=0, op_valid 1 cycle. → ctrl_MULT high exactly 1 cycle after acceptance, ctrl_DIV=0. Drive RDY with data_result=42 after 33 cycles → result=42, result_valid=1, exception=0; hold until result_ack.
- Div by zero: op_a=10, op_b=0, op_is_div=1; multdiv returns data_exception=1 with RDY. → ctrl_DIV single pulse; result_exception=1, result_timeout=0.
- Timeout: request accepted, RDY never asserted. → result_valid rises TIMEOUT+1 cycles after LAUNCH, with result=0, result_exception=1, result_timeout=1.
- RDY on final timeout cycle: RDY with data_result=0x1234 at counter=TIMEOUT-1. → result=0x1234, result_timeout=0.
- Busy rejection: second op_valid with op_a=99 while in WAIT. → op_ready=0, data_operandA unchanged, no extra start pulse.
- Reset mid-WAIT: reset=0 for 1 cycle, then RDY arrives. → busy=0, result_valid=0, no capture, op_ready=1.
